pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the fetch stage of the pipelined datapath. It replaces the fixed PC register and +4 adder pair with one block. The block holds the PC and computes the sequential address. It also selects among sequential, branch, jump, register-jump and exception targets, supports stall, halt and resume, and flags misaligned register jumps. Its outputs drive instruction-memory addressing and the IF/ID pipeline register.

---
 rtl/pc_pkg.sv | 22 ++
 rtl/pc_adder.sv | 12 +
 rtl/pc_sequencer.sv | 145 ++++++++++++++
 tb/tb_pc_sequencer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and default vectors for the fetch-stage PC sequencer.
package pc_pkg;

  typedef enum logic [1:0] {
    START,
    RUN,
    HALT
  } state_e;

  typedef enum logic [2:0] {
    SEQ,
    BR,
    J,
    JR,
    EXC,
    HOLD
  } src_e;

  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_0180;

endpackage

// File: rtl/pc_adder.sv
// Plain modulo-2^WIDTH adder used for the sequential and branch targets.
module pc_adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC register with next-PC priority mux, halt/resume
// and exception/misaligned-register-jump trapping.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned     WIDTH        = 32,
  parameter int unsigned     INC          = 4,
  parameter int unsigned     ALIGN_BITS   = 2,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(RESET_VEC_DEF),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(EXC_VEC_DEF)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             BranchTaken,
  input  logic [WIDTH-1:0] BranchOffset,
  input  logic             Jump,
  input  logic [WIDTH-1:0] JumpTarget,
  input  logic             JumpReg,
  input  logic [WIDTH-1:0] RegTarget,
  input  logic             Exception,
  input  logic             Halt,
  input  logic             Resume,
  output logic [WIDTH-1:0] PCResult,
  output logic [WIDTH-1:0] PCAddResult,
  output logic             PCValid,
  output logic [WIDTH-1:0] EPC,
  output logic             MisalignErr
);

  localparam logic [WIDTH-1:0] ALIGN_MASK =
    WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

  state_e           state_q, state_d;
  src_e             src;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             valid_q, valid_d;
  logic             mis_q, mis_d;
  logic [WIDTH-1:0] seq_pc, br_pc, br_off;
  logic             jr_bad;

  pc_adder #(.WIDTH(WIDTH)) u_seq_add (
    .a_i  (pc_q),
    .b_i  (WIDTH'(INC)),
    .sum_o(seq_pc)
  );

  assign br_off = BranchOffset << ALIGN_BITS;

  pc_adder #(.WIDTH(WIDTH)) u_br_add (
    .a_i  (seq_pc),
    .b_i  (br_off),
    .sum_o(br_pc)
  );

  assign jr_bad = JumpReg && ((RegTarget & ALIGN_MASK) != '0);

  always_comb begin
    src     = SEQ;
    state_d = state_q;
    epc_d   = epc_q;
    mis_d   = 1'b0;
    unique case (state_q)
      START: begin
        src     = HOLD;
        state_d = RUN;
      end
      RUN: begin
        if (Exception) begin
          src   = EXC;
          epc_d = pc_q;
        end else if (jr_bad) begin
          src   = EXC;
          epc_d = pc_q;
          mis_d = 1'b1;
        end else if (Stall) begin
          src = HOLD;
          if (Halt) state_d = HALT;
        end else if (JumpReg) begin
          src = JR;
        end else if (Jump) begin
          src = J;
        end else if (BranchTaken) begin
          src = BR;
        end else if (Halt) begin
          src     = HOLD;
          state_d = HALT;
        end
      end
      HALT: begin
        if (Exception) begin
          src     = EXC;
          epc_d   = pc_q;
          state_d = RUN;
        end else begin
          src = HOLD;
          if (Resume) state_d = RUN;
        end
      end
      default: begin
        src     = HOLD;
        state_d = START;
      end
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    unique case (src)
      SEQ:     pc_d = seq_pc;
      BR:      pc_d = br_pc;
      J:       pc_d = JumpTarget;
      JR:      pc_d = RegTarget;
      EXC:     pc_d = EXC_VECTOR;
      default: pc_d = pc_q;
    endcase
  end

  // Valid tracks the state being entered, so it rises with the first fetch.
  assign valid_d = (state_d == RUN);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= START;
      pc_q    <= RESET_VECTOR;
      epc_q   <= '0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
    end
  end

  assign PCResult    = pc_q;
  assign PCAddResult = seq_pc;
  assign PCValid     = valid_q;
  assign EPC         = epc_q;
  assign MisalignErr = mis_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (32-bit and 16-bit builds).
module tb_pc_sequencer;

  logic        Clk = 1'b0;
  logic        Reset, Stall, BranchTaken, Jump, JumpReg;
  logic        Exception, Halt, Resume;
  logic [31:0] BranchOffset, JumpTarget, RegTarget;
  logic [31:0] PCResult, PCAddResult, EPC;
  logic        PCValid, MisalignErr;

  logic        Reset16, Jump16;
  logic [15:0] JumpTarget16;
  logic [15:0] PC16, PCAdd16, EPC16;
  logic        Valid16, Mis16;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  pc_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall),
    .BranchTaken(BranchTaken), .BranchOffset(BranchOffset),
    .Jump(Jump), .JumpTarget(JumpTarget),
    .JumpReg(JumpReg), .RegTarget(RegTarget),
    .Exception(Exception), .Halt(Halt), .Resume(Resume),
    .PCResult(PCResult), .PCAddResult(PCAddResult),
    .PCValid(PCValid), .EPC(EPC), .MisalignErr(MisalignErr)
  );

  pc_sequencer #(
    .WIDTH(16), .INC(2), .ALIGN_BITS(1),
    .RESET_VECTOR(16'h0010), .EXC_VECTOR(16'h0180)
  ) dut16 (
    .Clk(Clk), .Reset(Reset16), .Stall(1'b0),
    .BranchTaken(1'b0), .BranchOffset(16'h0),
    .Jump(Jump16), .JumpTarget(JumpTarget16),
    .JumpReg(1'b0), .RegTarget(16'h0),
    .Exception(1'b0), .Halt(1'b0), .Resume(1'b0),
    .PCResult(PC16), .PCAddResult(PCAdd16),
    .PCValid(Valid16), .EPC(EPC16), .MisalignErr(Mis16)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic jump_to(input logic [31:0] t);
    Jump = 1'b1;
    JumpTarget = t;
    step();
    Jump = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Reset16 = 1'b1;
    Stall = 0; BranchTaken = 0; Jump = 0; JumpReg = 0;
    Exception = 0; Halt = 0; Resume = 0;
    BranchOffset = 0; JumpTarget = 0; RegTarget = 0;
    Jump16 = 0; JumpTarget16 = 0;
    #12;
    chk("rst_pc", PCResult, 32'h0);
    chk("rst_add", PCAddResult, 32'h4);
    chk("rst_valid", {31'b0, PCValid}, 32'h0);
    chk("rst_epc", EPC, 32'h0);
    chk("rst_mis", {31'b0, MisalignErr}, 32'h0);
    chk("rst16_pc", {16'b0, PC16}, 32'h0010);
    Reset = 1'b0; Reset16 = 1'b0;
    step();
    chk("run0_pc", PCResult, 32'h0);
    chk("run0_valid", {31'b0, PCValid}, 32'h1);
    step(); chk("seq4", PCResult, 32'h4);
    step(); chk("seq8", PCResult, 32'h8);
    step(); chk("seq12", PCResult, 32'hC);
    chk("seq12_add", PCAddResult, 32'h10);

    jump_to(32'h40);
    chk("j40", PCResult, 32'h40);
    BranchTaken = 1; BranchOffset = 32'hFFFF_FFFE;
    step(); chk("br_neg", PCResult, 32'h3C);
    BranchTaken = 0;
    jump_to(32'h1000);
    chk("j1000", PCResult, 32'h1000);

    jump_to(32'h100);
    Stall = 1; BranchTaken = 1; BranchOffset = 32'h4;
    step(); chk("stall1", PCResult, 32'h100);
    step(); chk("stall2", PCResult, 32'h100);
    Stall = 0;
    step(); chk("br_after", PCResult, 32'h114);
    BranchTaken = 0;

    jump_to(32'h200);
    JumpReg = 1; RegTarget = 32'h302;
    step();
    chk("mis_pc", PCResult, 32'h180);
    chk("mis_epc", EPC, 32'h200);
    chk("mis_pulse", {31'b0, MisalignErr}, 32'h1);
    JumpReg = 0;
    step();
    chk("mis_clr", {31'b0, MisalignErr}, 32'h0);
    chk("mis_next", PCResult, 32'h184);

    jump_to(32'h200);
    Stall = 1; JumpReg = 1;
    step();
    chk("mis_st_pc", PCResult, 32'h180);
    chk("mis_st_epc", EPC, 32'h200);
    chk("mis_st_pulse", {31'b0, MisalignErr}, 32'h1);
    Stall = 0; JumpReg = 0;
    step();
    chk("mis_st_clr", {31'b0, MisalignErr}, 32'h0);

    JumpReg = 1; RegTarget = 32'h300;
    step(); chk("jr_ok", PCResult, 32'h300);
    JumpReg = 0;

    jump_to(32'h20);
    Halt = 1;
    step();
    chk("halt_pc", PCResult, 32'h20);
    chk("halt_valid", {31'b0, PCValid}, 32'h0);
    Halt = 0; Jump = 1; JumpTarget = 32'h900;
    step();
    chk("halt_hold", PCResult, 32'h20);
    chk("halt_valid2", {31'b0, PCValid}, 32'h0);
    Jump = 0; Resume = 1;
    step();
    chk("res_valid", {31'b0, PCValid}, 32'h1);
    chk("res_pc", PCResult, 32'h20);
    Resume = 0;
    step(); chk("res_seq", PCResult, 32'h24);
    Halt = 1;
    step(); chk("halt2_valid", {31'b0, PCValid}, 32'h0);
    Halt = 0; Exception = 1;
    step();
    chk("hexc_pc", PCResult, 32'h180);
    chk("hexc_valid", {31'b0, PCValid}, 32'h1);
    Exception = 0;
    step(); chk("hexc_run", PCResult, 32'h184);

    Halt = 1; Jump = 1; JumpTarget = 32'h500;
    step();
    chk("halt_redir", PCResult, 32'h500);
    chk("halt_redir_v", {31'b0, PCValid}, 32'h1);
    Halt = 0; Jump = 0;
    step(); chk("halt_redir_n", PCResult, 32'h504);

    Jump16 = 1; JumpTarget16 = 16'hFFFE;
    step();
    chk("w16_pc", {16'b0, PC16}, 32'hFFFE);
    chk("w16_add", {16'b0, PCAdd16}, 32'h0);
    Jump16 = 0;
    step(); chk("w16_wrap", {16'b0, PC16}, 32'h0);
    step(); chk("w16_next", {16'b0, PC16}, 32'h2);

    #2;
    Reset16 = 1; Reset = 1;
    #1;
    chk("arst16_pc", {16'b0, PC16}, 32'h0010);
    chk("arst16_v", {31'b0, Valid16}, 32'h0);
    chk("arst_pc", PCResult, 32'h0);
    chk("arst_v", {31'b0, PCValid}, 32'h0);
    chk("arst_epc", EPC, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
